tlv493_sample_filter: RTL and testbench
=======================================

# tlv493_sample_filter

Downstream conditioning stage for the TLV493 magnetic sensor reader. It takes each decoded sample (12-bit two's-complement X/Y/Z, temperature, 2-bit frame counter) with a one-cycle valid strobe, and subtracts per-axis offsets loaded over Avalon. It then averages 2^k samples and publishes the filtered vector on a valid-strobed output bus and in Avalon registers. It also checks frame-counter continuity and counts discontinuities.

## Interface
- AVG_LOG2_MAX, 4, largest allowed averaging exponent k; the accumulator width per axis is 16+AVG_LOG2_MAX.
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- sample_valid  in  1  one-cycle strobe; mag_*, temp and frame are valid in that cycle.
- mag_x, mag_y, mag_z  in  12 each  raw signed field samples.
- temp  in  12  raw temperature; latched unfiltered.
- frame  in  2  sensor frame counter.
- address  in  16  Avalon word address; register index = address>>8.
- read, write  in  1  Avalon strobes.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data.
- waitrequest  out  1  Avalon wait.
- out_valid  out  1  one-cycle strobe per averaged result.
- out_x, out_y, out_z  out  16 each  signed averaged, offset-corrected field.

## Operation
- **Register map (index: meaning):**
  - 0: ctrl.
    - bit0 enable (rw, reset 1).
    - bit1 clear (write-1, self-clearing; reads 0).
  - 1: avg_log2, reset 0. Writes above AVG_LOG2_MAX are clipped to AVG_LOG2_MAX.
  - 2/3/4: offset_x/y/z, 16-bit signed, reset 0.
  - 5/6/7: filtered x/y/z, sign-extended to 32 bits.
  - 8: last temp, zero-extended.
  - 9: out_count, 32-bit, wraps.
  - 10: frame_err_count, 16-bit, saturates at 0xFFFF.
  - 11: status {fill_count[15:8], last frame[1:0]}.
  - Unmapped indices read 0 and ignore writes.
- **Stage 1 (on sample_valid && enable):**
  - diff_a = sext16(mag_a) − offset_a, 16-bit wrap-around arithmetic.
  - Latch temp.
  - Frame check: if seen_first is set and frame ≠ (last_frame+1) mod 4, increment frame_err_count (saturating).
  - Update last_frame; set seen_first.
  - The sample is accumulated regardless of frame errors.
- **Stage 2:**
  - acc_a += sext(diff_a); fill_count += 1.
  - When fill_count reaches 2^avg_log2:
    - filtered_a = acc_a >>> avg_log2 (arithmetic shift, truncated to 16 bits).
    - out_valid = 1; out_count += 1.
    - acc and fill_count are cleared in the same cycle.
- **Averaging-window reset events:** acc, fill_count and any in-flight stage-1 sample are flushed when any of the following occurs:
  - a write to avg_log2;
  - enable is written 0;
  - clear is written 1.
- **Clear** additionally zeroes out_count, frame_err_count and seen_first. Offsets and filtered values are retained.
- **Simultaneous events:**
  - clear or flush in the same cycle as sample_valid: the flush wins and the sample is discarded.
  - Register read in the same cycle as out_valid: returns the pre-update value.
- **Disabled (enable = 0):** sample_valid is ignored; out_valid stays 0.

## Timing
- **Reset values:**
  - out_valid = 0; out_x/y/z = 0; readdata = 0; waitrequest = 0.
  - All counters and accumulators = 0; seen_first = 0.
- **Latency:** out_valid is high in cycle N+2 when the completing sample's sample_valid is at cycle N.
  - Back-to-back sample_valid on every cycle is fully supported with no loss.
  - With avg_log2 = 0, every sample yields an output.
- **out_x/y/z and registers 5–7** update in the same cycle out_valid is high, and hold until the next result.
- **Avalon read:** one wait state.
  - waitrequest = read && !rd_ack.
  - rd_ack is registered high the cycle after read is first seen.
  - readdata is registered and valid when waitrequest drops; rd_ack clears when read deasserts.
- **Avalon write:** zero wait states; takes effect at the next clock edge.
- **Reset mid-accumulation:** all state returns to reset values immediately (asynchronous); no partial output is produced.

## Test plan
- **Averaging:**
  - Stimulus: avg_log2 = 2, offsets 0, four samples x = 100, 101, 102, 103 (y = −8 repeated, z = 0).
  - Response: single out_valid 2 cycles after the 4th strobe; out_x = 101, out_y = −8; out_count = 1.
- **Offset and sign:**
  - Stimulus: avg_log2 = 0, offset_x = 50, mag_x = 0x800 (−2048).
  - Response: out_x = −2098 (0xF7CE); reg 5 reads 0xFFFFF7CE.
- **Frame check:**
  - Stimulus: frames 0, 1, 2, 0, 1.
  - Response: frame_err_count = 1; 5 samples accumulated. Then 70000 bad frames → count stays 0xFFFF.
- **Flush collision:**
  - Stimulus: avg_log2 = 1, one sample, then clear written in the same cycle as the second sample_valid.
  - Response: no out_valid; fill_count = 0; counters 0.
- **Clipping and disable:**
  - Stimulus: write avg_log2 = 7 → reads 4. Then enable = 0 and 20 samples.
  - Response: no out_valid; fill_count stays 0.
- **Avalon handshake:**
  - Stimulus: read held on reg 9.
  - Response: waitrequest high exactly 1 cycle, then readdata valid. Assert async reset mid-window → out_valid never pulses and all registers read their reset values.

Source files
------------

// File: rtl/tlv493_sample_filter.sv
// tlv493_sample_filter: offset correction, 2^k averaging and frame
// continuity checking for decoded TLV493 samples, with Avalon registers.
module tlv493_sample_filter #(
  parameter int AVG_LOG2_MAX = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sample_valid,
  input  logic [11:0] mag_x,
  input  logic [11:0] mag_y,
  input  logic [11:0] mag_z,
  input  logic [11:0] temp,
  input  logic [1:0]  frame,
  input  logic [15:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        out_valid,
  output logic [15:0] out_x,
  output logic [15:0] out_y,
  output logic [15:0] out_z
);
  localparam int AW = 16 + AVG_LOG2_MAX;

  logic [7:0]  idx;
  logic        wr_ctrl;
  logic        wr_avg;
  logic        flush;
  logic        clear;
  logic        take;
  logic        done;
  logic        enable;
  logic        seen_first;
  logic        s1_valid;
  logic        rd_ack;
  logic [7:0]  avg_log2;
  logic [7:0]  fill_count;
  logic [7:0]  fill_nxt;
  logic [1:0]  last_frame;
  logic [11:0] temp_q;
  logic [31:0] out_count;
  logic [31:0] rd_mux;
  logic [15:0] frame_err;
  logic        unused_ok;

  logic [11:0]          mag     [3];
  logic signed [15:0]   offset  [3];
  logic signed [15:0]   diff    [3];
  logic signed [15:0]   s1_d    [3];
  logic signed [15:0]   filt    [3];
  logic signed [15:0]   avg_res [3];
  logic signed [AW-1:0] acc     [3];
  logic signed [AW-1:0] acc_nxt [3];
  logic signed [AW-1:0] shifted [3];

  assign idx       = address[15:8];
  assign unused_ok = ^address[7:0];

  assign wr_ctrl = write && (idx == 8'd0);
  assign wr_avg  = write && (idx == 8'd1);
  assign clear   = wr_ctrl && writedata[1];
  // Any window-resetting write also kills the sample arriving this cycle.
  assign flush   = wr_avg || (wr_ctrl && (!writedata[0] || writedata[1]));
  assign take    = sample_valid && enable && !flush;

  assign mag[0] = mag_x;
  assign mag[1] = mag_y;
  assign mag[2] = mag_z;

  assign fill_nxt = fill_count + 8'd1;
  assign done     = fill_nxt == (8'd1 << avg_log2);

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      diff[i]    = {{4{mag[i][11]}}, mag[i]} - offset[i];
      acc_nxt[i] = acc[i] + {{AVG_LOG2_MAX{s1_d[i][15]}}, s1_d[i]};
      shifted[i] = acc_nxt[i] >>> avg_log2;
      avg_res[i] = shifted[i][15:0];
    end
  end

  assign out_x       = filt[0];
  assign out_y       = filt[1];
  assign out_z       = filt[2];
  assign waitrequest = read && !rd_ack;

  always_comb begin
    rd_mux = '0;
    case (idx)
      8'd0:    rd_mux = {31'd0, enable};
      8'd1:    rd_mux = {24'd0, avg_log2};
      8'd2:    rd_mux = {16'd0, offset[0]};
      8'd3:    rd_mux = {16'd0, offset[1]};
      8'd4:    rd_mux = {16'd0, offset[2]};
      8'd5:    rd_mux = {{16{filt[0][15]}}, filt[0]};
      8'd6:    rd_mux = {{16{filt[1][15]}}, filt[1]};
      8'd7:    rd_mux = {{16{filt[2][15]}}, filt[2]};
      8'd8:    rd_mux = {20'd0, temp_q};
      8'd9:    rd_mux = out_count;
      8'd10:   rd_mux = {16'd0, frame_err};
      8'd11:   rd_mux = {16'd0, fill_count, 6'd0, last_frame};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      enable     <= 1'b1;
      avg_log2   <= '0;
      seen_first <= 1'b0;
      last_frame <= '0;
      temp_q     <= '0;
      frame_err  <= '0;
      out_count  <= '0;
      fill_count <= '0;
      s1_valid   <= 1'b0;
      out_valid  <= 1'b0;
      rd_ack     <= 1'b0;
      readdata   <= '0;
      for (int i = 0; i < 3; i++) begin
        offset[i] <= '0;
        s1_d[i]   <= '0;
        acc[i]    <= '0;
        filt[i]   <= '0;
      end
    end else begin
      if (wr_ctrl)
        enable <= writedata[0];
      if (wr_avg)
        avg_log2 <= (writedata > 32'(AVG_LOG2_MAX)) ?
                    8'(AVG_LOG2_MAX) : writedata[7:0];
      for (int i = 0; i < 3; i++)
        if (write && idx == 8'(i + 2))
          offset[i] <= writedata[15:0];

      s1_valid <= take;
      if (take) begin
        s1_d       <= diff;
        temp_q     <= temp;
        last_frame <= frame;
        seen_first <= 1'b1;
        if (seen_first && frame != last_frame + 2'd1 &&
            frame_err != 16'hFFFF)
          frame_err <= frame_err + 16'd1;
      end

      out_valid <= 1'b0;
      if (flush) begin
        fill_count <= '0;
        for (int i = 0; i < 3; i++) acc[i] <= '0;
      end else if (s1_valid) begin
        if (done) begin
          filt       <= avg_res;
          out_valid  <= 1'b1;
          out_count  <= out_count + 32'd1;
          fill_count <= '0;
          for (int i = 0; i < 3; i++) acc[i] <= '0;
        end else begin
          acc        <= acc_nxt;
          fill_count <= fill_nxt;
        end
      end

      if (clear) begin
        out_count  <= '0;
        frame_err  <= '0;
        seen_first <= 1'b0;
      end

      // One wait state: capture on the first cycle read is seen.
      if (!read) begin
        rd_ack <= 1'b0;
      end else if (!rd_ack) begin
        rd_ack   <= 1'b1;
        readdata <= rd_mux;
      end
    end
  end
endmodule

// File: tb/tb_tlv493_sample_filter.sv
// Randomized bench for tlv493_sample_filter with a window/sum reference
// model and per-cycle output comparison.
module tb_tlv493_sample_filter;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sample_valid = 1'b0;
  logic [11:0] mag_x = '0, mag_y = '0, mag_z = '0, temp = '0;
  logic [1:0]  frame = '0;
  logic [15:0] address = '0;
  logic        read = 1'b0, write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        waitrequest, out_valid;
  logic [15:0] out_x, out_y, out_z;

  tlv493_sample_filter #(.AVG_LOG2_MAX(4)) dut (
    .clock(clock), .reset(reset), .sample_valid(sample_valid),
    .mag_x(mag_x), .mag_y(mag_y), .mag_z(mag_z), .temp(temp),
    .frame(frame), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata),
    .waitrequest(waitrequest), .out_valid(out_valid),
    .out_x(out_x), .out_y(out_y), .out_z(out_z)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  int pulses = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: running window sums, scheduled results.
  typedef struct {
    int               due;
    logic [2:0][15:0] v;
  } pend_t;

  pend_t            pend[$];
  int               edge_cnt = 0;
  int               m_sum[3] = '{0, 0, 0};
  int               m_n = 0, m_avg = 0, m_last = 0, m_err = 0;
  int               m_outcnt = 0;
  bit               m_en = 1, m_seen = 0, m_ev = 0;
  logic [11:0]      m_temp = '0;
  logic [2:0][15:0] m_off = '0;
  logic [2:0][15:0] m_ex = '0;

  task automatic model_step();
    logic [7:0]         i;
    logic               fl, clr;
    logic [2:0][11:0]   mg;
    logic signed [15:0] w;
    int                 d;
    pend_t              p;
    if (reset) begin
      pend.delete();
      m_sum = '{0, 0, 0};
      m_n = 0; m_avg = 0; m_last = 0; m_err = 0; m_outcnt = 0;
      m_en = 1; m_seen = 0; m_ev = 0;
      m_temp = '0; m_off = '0; m_ex = '0;
      return;
    end
    edge_cnt++;
    i   = address[15:8];
    fl  = write && (i == 1 || (i == 0 && (!writedata[0] || writedata[1])));
    clr = write && i == 0 && writedata[1];
    m_ev = 0;
    if (pend.size() > 0 && pend[0].due == edge_cnt) begin
      if (!fl) begin
        m_ev = 1;
        m_ex = pend[0].v;
        m_outcnt++;
      end
      void'(pend.pop_front());
    end
    if (fl) begin
      m_sum = '{0, 0, 0};
      m_n = 0;
    end
    if (clr) begin
      m_outcnt = 0; m_err = 0; m_seen = 0;
    end
    if (sample_valid && m_en && !fl) begin
      mg = {mag_z, mag_y, mag_x};
      for (int a = 0; a < 3; a++) begin
        d = int'($signed(mg[a])) - int'($signed(m_off[a]));
        w = 16'(d);
        m_sum[a] += int'(w);
      end
      m_temp = temp;
      if (m_seen && int'(frame) != (m_last + 1) % 4 && m_err < 65535)
        m_err++;
      m_last = int'(frame);
      m_seen = 1;
      m_n++;
      if (m_n == (1 << m_avg)) begin
        p.due = edge_cnt + 1;
        for (int a = 0; a < 3; a++) p.v[a] = 16'(m_sum[a] >>> m_avg);
        pend.push_back(p);
        m_sum = '{0, 0, 0};
        m_n = 0;
      end
    end
    if (write) begin
      if (i == 0) m_en = writedata[0];
      if (i == 1) m_avg = (writedata > 4) ? 4 : int'(writedata);
      if (i >= 2 && i <= 4) m_off[i - 2] = writedata[15:0];
    end
  endtask

  initial forever begin
    @(posedge clock or posedge reset);
    model_step();
  end

  initial forever begin
    @(negedge clock);
    if (out_valid) pulses++;
    if (reset)
      check("reset_out", {out_valid, out_x, out_y, out_z}, 64'd0);
    else
      check("out", {out_valid, out_x, out_y, out_z},
            {m_ev, m_ex[0], m_ex[1], m_ex[2]});
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  task automatic cyc(input bit sv, input logic [11:0] x, y, z,
                     input logic [1:0] f, input bit wr,
                     input logic [7:0] ix, input logic [31:0] wd);
    sample_valid = sv;
    mag_x = x; mag_y = y; mag_z = z; frame = f;
    temp = 12'($urandom);
    write = wr;
    address = {ix, 8'h00};
    writedata = wd;
    @(negedge clock);
    sample_valid = 1'b0;
    write = 1'b0;
  endtask

  task automatic wr(input logic [7:0] ix, input logic [31:0] wd);
    cyc(0, 0, 0, 0, 0, 1, ix, wd);
  endtask

  task automatic smp(input logic [11:0] x, y, z, input logic [1:0] f);
    cyc(1, x, y, z, f, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic rd(input logic [7:0] ix, input logic [31:0] exp,
                    input string name);
    int n;
    address = {ix, 8'h00};
    read = 1'b1;
    n = 0;
    #1;
    while (waitrequest && n < 4) begin
      @(negedge clock);
      n++;
    end
    check({name, "_wait"}, 64'(n), 64'd1);
    check(name, 64'(readdata), 64'(exp));
    read = 1'b0;
    @(negedge clock);
  endtask

  function automatic logic [31:0] sx(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  initial begin
    int p0;
    logic [1:0] nf;
    idle(3);
    reset = 1'b0;
    idle(2);

    rd(0, 32'd1, "rst_ctrl");
    rd(1, 32'd0, "rst_avg");
    rd(9, 32'd0, "rst_outcnt");
    rd(11, 32'd0, "rst_status");

    // Averaging window of four
    wr(1, 2);
    smp(12'd100, 12'hFF8, 0, 0);
    smp(12'd101, 12'hFF8, 0, 1);
    smp(12'd102, 12'hFF8, 0, 2);
    smp(12'd103, 12'hFF8, 0, 3);
    idle(3);
    check("avg_model_x", 64'(m_ex[0]), 64'd101);
    check("avg_pulses", 64'(pulses), 64'd1);
    rd(5, 32'd101, "avg_x");
    rd(6, 32'hFFFF_FFF8, "avg_y");
    rd(9, 32'd1, "avg_cnt");

    // Offset and sign
    wr(1, 0);
    wr(2, 50);
    smp(12'h800, 0, 0, 0);
    idle(3);
    check("off_model_x", 64'(m_ex[0]), 64'hF7CE);
    rd(5, 32'hFFFF_F7CE, "off_x");
    rd(9, 32'd2, "off_cnt");

    // Frame continuity
    wr(0, 3);
    wr(1, 3);
    smp(1, 1, 1, 0);
    smp(1, 1, 1, 1);
    smp(1, 1, 1, 2);
    smp(1, 1, 1, 0);
    smp(1, 1, 1, 1);
    idle(3);
    rd(10, 32'd1, "frm_err");
    rd(11, 32'h0000_0501, "frm_status");

    // Clear colliding with the completing sample
    wr(0, 3);
    wr(1, 1);
    p0 = pulses;
    smp(5, 5, 5, 2);
    cyc(1, 5, 5, 5, 3, 1, 0, 3);
    idle(3);
    check("col_pulses", 64'(pulses), 64'(p0));
    rd(11, 32'h0000_0002, "col_status");
    rd(9, 32'd0, "col_cnt");
    rd(10, 32'd0, "col_err");

    // Clipping and disable
    wr(1, 7);
    rd(1, 32'd4, "clip");
    wr(0, 0);
    p0 = pulses;
    for (int k = 0; k < 20; k++) smp(12'($urandom), 0, 0, 2'(k));
    idle(3);
    check("dis_pulses", 64'(pulses), 64'(p0));
    rd(11, 32'h0000_0002, "dis_status");
    rd(0, 32'd0, "dis_ctrl");
    rd(12, 32'd0, "unmapped");

    // Randomized traffic
    wr(0, 1);
    nf = 0;
    for (int k = 0; k < 3000; k++) begin
      bit         sv, w;
      logic [7:0] ix;
      logic [31:0] wd;
      sv = $urandom_range(0, 3) != 0;
      w  = $urandom_range(0, 19) == 0;
      ix = 8'($urandom_range(0, 5));
      if (ix == 5) ix = 8'd12;
      wd = $urandom;
      if (ix == 0) begin
        case ($urandom_range(0, 9))
          0: wd = 0;
          1: wd = 3;
          default: wd = 1;
        endcase
      end
      if (ix == 1) wd = $urandom_range(0, 6);
      if ($urandom_range(0, 9) == 0) nf = 2'($urandom);
      cyc(sv, 12'($urandom), 12'($urandom), 12'($urandom), nf, w, ix, wd);
      if (sv) nf = nf + 2'd1;
      if (w && ix == 0 && wd == 0) wr(0, 1);
    end
    idle(3);
    rd(5, sx(m_ex[0]), "rnd_x");
    rd(6, sx(m_ex[1]), "rnd_y");
    rd(7, sx(m_ex[2]), "rnd_z");
    rd(8, {20'd0, m_temp}, "rnd_temp");
    rd(9, 32'(m_outcnt), "rnd_cnt");
    rd(10, 32'(m_err), "rnd_err");
    rd(11, {16'd0, 8'(m_n), 6'd0, 2'(m_last)}, "rnd_status");
    rd(1, 32'(m_avg), "rnd_avg");

    // Frame error saturation
    wr(0, 3);
    wr(1, 0);
    for (int k = 0; k < 65600; k++) smp(12'($urandom), 0, 0, 0);
    idle(3);
    rd(10, 32'h0000_FFFF, "sat_err");
    rd(9, 32'd65600, "sat_cnt");

    // Async reset in the middle of a window
    wr(1, 4);
    wr(3, 32'h1234);
    for (int k = 0; k < 10; k++) smp(12'($urandom), 1, 1, 2'(k));
    p0 = pulses;
    #2 reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(20);
    check("rst_pulses", 64'(pulses), 64'(p0));
    rd(0, 32'd1, "post_ctrl");
    rd(1, 32'd0, "post_avg");
    rd(3, 32'd0, "post_offy");
    rd(5, 32'd0, "post_x");
    rd(8, 32'd0, "post_temp");
    rd(9, 32'd0, "post_cnt");
    rd(10, 32'd0, "post_err");
    rd(11, 32'd0, "post_status");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
